two_phase_clkgen: RTL and testbench
===================================

// Module: two_phase_clkgen
// PURPOSE
//  Debug-controllable generator of the two non-overlapping clock phases
//  (PHI1/nPHI1, PHI2/nPHI2) that drive the complementary CLK/nCLK enables of
//  every D_LATCH pair in the RV523 datapath. It sits upstream of all latch stages.
//  Derived from one fast master clock. Supports free-run, halt at a cycle
//  boundary and single-step, so the board LEDs can be read between CPU cycles.
// PARAMETERS
//  PHI_LEN   4   master CLK cycles each phase is held high (>=1)
//  DEAD_LEN  1   master CLK cycles with both phases low after each phase (>=1)
//  CNT_W     16  width of CYCLE_CNT
// PORTS
//  CLK        in   1      master clock, all state on rising edge
//  nRST       in   1      reset, asynchronous, active-low
//  RUN        in   1      level: free-run CPU cycles while high
//  STEP       in   1      sampled each CLK; high while halted -> exactly one CPU cycle
//  PHI1       out  1      phase 1 (master latch enable)
//  nPHI1      out  1      complement of PHI1
//  PHI2       out  1      phase 2 (slave latch enable)
//  nPHI2      out  1      complement of PHI2
//  BUSY       out  1      high whenever not HALTED
//  CYCLE_DONE out  1      one-CLK pulse at completion of each CPU cycle
//  CYCLE_CNT  out  CNT_W  completed CPU cycles, wraps to 0
// BEHAVIOUR
//  - The design has one clock, CLK, and one reset, nRST. nRST is asynchronous
//    and active-low.
//  - While nRST is low, all outputs are forced immediately: PHI1=PHI2=0,
//    nPHI1=nPHI2=1, BUSY=0, CYCLE_DONE=0, CYCLE_CNT=0, and the mode is HALTED.
//  - All outputs are registered. Each nPHIx is a separate flop loaded with the
//    complement of the PHIx next-value, so nPHIx == ~PHIx on every cycle.
//  - CPU cycle = PH1 (PHI_LEN) -> GAP1 (DEAD_LEN) -> PH2 (PHI_LEN) ->
//    GAP2 (DEAD_LEN). Period = 2*(PHI_LEN+DEAD_LEN) CLKs.
//  - PHI1 and PHI2 are never high on the same cycle.
//  - Mode FSM states are HALTED, RUNNING and STEPPING.
//    HALTED: both phases low. RUN=1 -> RUNNING, else STEP=1 -> STEPPING.
//    On that same edge PHI1 rises (latency 1 edge) and BUSY=1.
//    RUN and STEP high together: RUN wins.
//  - RUNNING and STEPPING ignore STEP, which is not queued. RUN is only acted on
//    at the cycle boundary.
//  - Cycle boundary is the last CLK of GAP2. CYCLE_DONE=1 and CYCLE_CNT+1
//    (mod 2^CNT_W) on that edge.
//    The next mode is RUNNING with PH1 starting on the next edge if RUN=1,
//    else HALTED.
//    There is no extra idle cycle between back-to-back CPU cycles.
//  - A halt request (RUN falling) mid-cycle never truncates a phase; the
//    cycle always completes.
//  - Reset mid-phase drops the phases asynchronously, which is safe because
//    both phases go low.
//  - PHI_LEN<1 or DEAD_LEN<1 is an elaboration-time $error.
// STRUCTURE
//  - Package rv523_clk_pkg holds typedef enum mode_t {HALTED, RUNNING,
//    STEPPING} and typedef enum phase_t {PH1, GAP1, PH2, GAP2}.
//  - Sub-module rv523_phase_seq is the phase_t state plus a
//    $clog2(max(PHI_LEN,DEAD_LEN))-bit tick counter.
//    It has inputs start/continue and outputs phase and last_tick.
//    two_phase_clkgen wraps it with the mode FSM, output flops and CYCLE_CNT.
// TESTING (PHI_LEN=4, DEAD_LEN=1; period 10 CLKs)
//  1. Reset: assert nRST low mid-PH1.
//     -> PHI1=0 and nPHI1=1 within the same cycle, BUSY=0, CYCLE_CNT=0.
//  2. STEP pulse 1 CLK at edge 0.
//     -> PHI1 high on edges 0-3, both phases low on edge 4, PHI2 high on edges 5-8,
//        both low on edge 9.
//     -> CYCLE_DONE pulses at edge 9, CYCLE_CNT=1, then HALTED with BUSY=0.
//  3. Hold RUN high from edge 0, drop it at edge 25.
//     -> exactly 3 CPU cycles, CYCLE_DONE at edges 9, 19 and 29, CYCLE_CNT=3,
//        no phase activity after edge 29.
//  4. Drive STEP and RUN together from HALTED, and pulse STEP again during
//     STEPPING. -> RUNNING is entered, and the extra STEP produces no extra cycle.
//  5. Wrap: PHI_LEN=1, DEAD_LEN=1, CNT_W=4, run 16 cycles.
//     -> CYCLE_CNT goes 15 -> 0 with CYCLE_DONE=1 on that edge.
//  6. Always-on assertions: !(PHI1&&PHI2), nPHI1==~PHI1, nPHI2==~PHI2, and
//     BUSY==0 implies both phases are low.

Source files
------------

// File: rtl/rv523_clk_pkg.sv
// rv523_clk_pkg: shared mode/phase types for the RV523 two-phase clock generator
package rv523_clk_pkg;

    typedef enum logic [1:0] {HALTED, RUNNING, STEPPING} mode_t;

    typedef enum logic [1:0] {PH1, GAP1, PH2, GAP2} phase_t;

    // Number of master clocks a given phase lasts.
    function automatic int unsigned phase_len(input phase_t p, input int unsigned phi_len,
                                              input int unsigned dead_len);
        return (p == PH1 || p == PH2) ? phi_len : dead_len;
    endfunction

endpackage

// File: rtl/rv523_phase_seq.sv
// rv523_phase_seq: walks PH1 -> GAP1 -> PH2 -> GAP2 with a per-phase tick counter
module rv523_phase_seq
    import rv523_clk_pkg::*;
#(
    parameter int unsigned PHI_LEN  = 4,
    parameter int unsigned DEAD_LEN = 1
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   start,
    input  logic   cont,
    output phase_t phase,
    output logic   last_tick
);

    localparam int unsigned MAX_LEN = (PHI_LEN > DEAD_LEN) ? PHI_LEN : DEAD_LEN;
    localparam int TW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    phase_t        phase_q, phase_n;
    logic [TW-1:0] tick_q, tick_n;
    logic          cur_last;

    // Next phase/tick; phase and last_tick describe the state loaded on this edge
    // so the owner can register its outputs without an extra cycle of latency.
    always_comb begin
        cur_last  = tick_q == TW'(phase_len(phase_q, PHI_LEN, DEAD_LEN) - 1);
        phase_n   = phase_q;
        tick_n    = tick_q;
        if (start) begin
            phase_n = PH1;
            tick_n  = '0;
        end else if (cont) begin
            phase_n = cur_last ? phase_t'(phase_q + 2'd1) : phase_q;
            tick_n  = cur_last ? '0 : tick_q + 1'b1;
        end
        phase     = phase_n;
        last_tick = tick_n == TW'(phase_len(phase_n, PHI_LEN, DEAD_LEN) - 1);
    end

    // Rest at the final tick of GAP2 so an idle sequencer sits on a cycle boundary.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            phase_q <= GAP2;
            tick_q  <= TW'(DEAD_LEN - 1);
        end else begin
            phase_q <= phase_n;
            tick_q  <= tick_n;
        end
    end

endmodule

// File: rtl/two_phase_clkgen.sv
// two_phase_clkgen: debug-controllable non-overlapping PHI1/PHI2 generator with run/halt/step
module two_phase_clkgen
    import rv523_clk_pkg::*;
#(
    parameter int unsigned PHI_LEN  = 4,
    parameter int unsigned DEAD_LEN = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             RUN,
    input  logic             STEP,
    output logic             PHI1,
    output logic             nPHI1,
    output logic             PHI2,
    output logic             nPHI2,
    output logic             BUSY,
    output logic             CYCLE_DONE,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    if (PHI_LEN < 1 || DEAD_LEN < 1) begin : g_bad_params
        $error("two_phase_clkgen: PHI_LEN and DEAD_LEN must both be >= 1");
    end

    mode_t  mode_q, mode_n;
    phase_t seq_phase;
    logic   seq_last;
    logic   start;
    logic   boundary;
    logic   busy_n;

    rv523_phase_seq #(
        .PHI_LEN (PHI_LEN),
        .DEAD_LEN(DEAD_LEN)
    ) u_seq (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .cont     (mode_q != HALTED),
        .phase    (seq_phase),
        .last_tick(seq_last)
    );

    // Mode decisions: start only from HALTED (RUN beats STEP), and re-evaluate RUN
    // only on the edge that enters the last tick of GAP2.
    always_comb begin
        start    = mode_q == HALTED && (RUN || STEP);
        boundary = mode_q != HALTED && seq_phase == GAP2 && seq_last;
        mode_n   = mode_q;
        if (mode_q == HALTED)
            mode_n = RUN ? RUNNING : (STEP ? STEPPING : HALTED);
        else if (boundary)
            mode_n = RUN ? RUNNING : HALTED;
        busy_n   = mode_n != HALTED;
    end

    // Registered outputs; each complement is its own flop so nPHIx never glitches.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode_q     <= HALTED;
            PHI1       <= 1'b0;
            nPHI1      <= 1'b1;
            PHI2       <= 1'b0;
            nPHI2      <= 1'b1;
            BUSY       <= 1'b0;
            CYCLE_DONE <= 1'b0;
            CYCLE_CNT  <= '0;
        end else begin
            mode_q     <= mode_n;
            PHI1       <= busy_n && seq_phase == PH1;
            nPHI1      <= !(busy_n && seq_phase == PH1);
            PHI2       <= busy_n && seq_phase == PH2;
            nPHI2      <= !(busy_n && seq_phase == PH2);
            BUSY       <= busy_n;
            CYCLE_DONE <= boundary;
            CYCLE_CNT  <= CYCLE_CNT + CNT_W'(boundary);
        end
    end

endmodule

// File: tb/tb_two_phase_clkgen.sv
// tb_two_phase_clkgen: directed checks plus a cycle-position model for two configurations
module tb_two_phase_clkgen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_a = 1'b0, step_a = 1'b0, run_b = 1'b0, step_b = 1'b0;
    logic       phi1_a, nphi1_a, phi2_a, nphi2_a, busy_a, done_a;
    logic       phi1_b, nphi1_b, phi2_b, nphi2_b, busy_b, done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad = 0;

    logic ma_busy, mb_busy, ma_done, mb_done;
    int   ma_pos, mb_pos, ma_cnt, mb_cnt;

    two_phase_clkgen #(.PHI_LEN(4), .DEAD_LEN(1), .CNT_W(16)) dut_a (
        .CLK(clk), .nRST(rst_n), .RUN(run_a), .STEP(step_a),
        .PHI1(phi1_a), .nPHI1(nphi1_a), .PHI2(phi2_a), .nPHI2(nphi2_a),
        .BUSY(busy_a), .CYCLE_DONE(done_a), .CYCLE_CNT(cnt_a)
    );

    two_phase_clkgen #(.PHI_LEN(1), .DEAD_LEN(1), .CNT_W(4)) dut_b (
        .CLK(clk), .nRST(rst_n), .RUN(run_b), .STEP(step_b),
        .PHI1(phi1_b), .nPHI1(nphi1_b), .PHI2(phi2_b), .nPHI2(nphi2_b),
        .BUSY(busy_b), .CYCLE_DONE(done_b), .CYCLE_CNT(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a CPU cycle is a position 0..per-1 counted from its start edge.
    task automatic mstep(input logic run, input logic step, input int per, inout logic busy,
                         inout int pos, inout int cnt, output logic done, input int modv);
        done = 1'b0;
        if (busy) pos = (pos + 1) % per;
        else if (run || step) begin
            busy = 1'b1;
            pos  = 0;
        end
        if (busy && pos == per - 1) begin
            done = 1'b1;
            cnt  = (cnt + 1) % modv;
            busy = run;
        end
    endtask

    // Advance both models on every edge, reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_busy = 1'b0; ma_pos = 9; ma_cnt = 0; ma_done = 1'b0;
            mb_busy = 1'b0; mb_pos = 3; mb_cnt = 0; mb_done = 1'b0;
        end else begin
            mstep(run_a, step_a, 10, ma_busy, ma_pos, ma_cnt, ma_done, 65536);
            mstep(run_b, step_b, 4, mb_busy, mb_pos, mb_cnt, mb_done, 16);
        end
    end

    task automatic cmp_inst(input string tag, input logic phi1, input logic nphi1, input logic phi2,
                            input logic nphi2, input logic busy, input logic done, input int cnt,
                            input logic mbusy, input int mpos, input int mcnt, input logic mdone,
                            input int p, input int d);
        logic e1, e2;
        e1 = mbusy && mpos < p;
        e2 = mbusy && mpos >= p + d && mpos < 2 * p + d;
        chk({tag, "_phi1"}, phi1, e1);
        chk({tag, "_phi2"}, phi2, e2);
        chk({tag, "_busy"}, busy, mbusy);
        chk({tag, "_done"}, done, mdone);
        chk({tag, "_cnt"}, cnt, mcnt);
        chk({tag, "_nphi1"}, nphi1, !phi1);
        chk({tag, "_nphi2"}, nphi2, !phi2);
        chk({tag, "_overlap"}, phi1 && phi2, 0);
        chk({tag, "_idle_phase"}, !busy && (phi1 || phi2), 0);
    endtask

    // Compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst("a", phi1_a, nphi1_a, phi2_a, nphi2_a, busy_a, done_a, int'(cnt_a),
                     ma_busy, ma_pos, ma_cnt, ma_done, 4, 1);
            cmp_inst("b", phi1_b, nphi1_b, phi2_b, nphi2_b, busy_b, done_b, int'(cnt_b),
                     mb_busy, mb_pos, mb_cnt, mb_done, 1, 1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run_a = 1'b0; step_a = 1'b0; run_b = 1'b0; step_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [39:0] l1, l2, ld, lb, lp;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_phi1", phi1_a, 0);
        chk("rst_nphi1", nphi1_a, 1);
        chk("rst_nphi2", nphi2_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_cnt", cnt_a, 0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of PH1
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        @(negedge clk);
        chk("t1_phi1_before", phi1_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_phi1", phi1_a, 0);
        chk("t1_nphi1", nphi1_a, 1);
        chk("t1_busy", busy_a, 0);
        chk("t1_cnt", cnt_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single step: edge e is logged into bit e
        l1 = '0; l2 = '0; ld = '0; lb = '0;
        step_a = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            step_a = 1'b0;
            l1[e] = phi1_a; l2[e] = phi2_a; ld[e] = done_a; lb[e] = busy_a;
        end
        chk("t2_phi1", l1[11:0], 12'h00f);
        chk("t2_phi2", l2[11:0], 12'h1e0);
        chk("t2_done", ld[11:0], 12'h200);
        chk("t2_busy", lb[11:0], 12'h1ff);
        chk("t2_cnt", cnt_a, 1);

        // Free run, RUN first sampled low at edge 25
        do_reset();
        ld = '0; lp = '0;
        run_a = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (e == 24) run_a = 1'b0;
            ld[e] = done_a; lp[e] = phi1_a | phi2_a;
        end
        chk("t3_done", ld, 40'h0020080200);
        chk("t3_back_to_back", lp[10], 1);
        chk("t3_quiet", lp[39:30], 0);
        chk("t3_cnt", cnt_a, 3);

        // RUN and STEP together: RUN wins, cycles continue while RUN holds
        do_reset();
        ld = '0;
        run_a = 1'b1; step_a = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            step_a = 1'b0;
            if (e == 14) run_a = 1'b0;
            ld[e] = done_a;
        end
        chk("t4a_done", ld[29:0], 30'h00080200);
        chk("t4a_cnt", cnt_a, 2);

        // Extra STEP during STEPPING is ignored
        do_reset();
        ld = '0; lp = '0;
        step_a = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            step_a = (e == 3);
            ld[e] = done_a; lp[e] = phi1_a | phi2_a;
        end
        chk("t4b_done", ld[19:0], 20'h00200);
        chk("t4b_quiet", lp[19:10], 0);
        chk("t4b_cnt", cnt_a, 1);

        // Counter wrap on the short configuration (period 4)
        do_reset();
        run_b = 1'b1;
        for (int e = 0; e < 68; e++) begin
            @(negedge clk);
            if (e == 62) begin
                chk("t5_cnt_before", cnt_b, 15);
                chk("t5_done_before", done_b, 0);
            end
            if (e == 63) begin
                chk("t5_cnt_wrap", cnt_b, 0);
                chk("t5_done_wrap", done_b, 1);
                run_b = 1'b0;
            end
        end
        chk("t5_idle", busy_b, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
